// File: rtl/exec_pkg.sv
// Purpose: shared types, widths and pipeline-buffer field layout for execute/memory stages.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package exec_pkg;

  localparam int DATA_W        = 24;
  localparam int MULDIV_CYCLES = DATA_W;
  localparam int BUF_W         = 86;

  typedef enum logic [1:0] {
    OPT_ALU  = 2'b00,
    OPT_MEM  = 2'b01,
    OPT_MOV  = 2'b10,
    OPT_MOV2 = 2'b11
  } optype_e;

  typedef enum logic [3:0] {
    OPC_ADD = 4'd0,
    OPC_SUB = 4'd1,
    OPC_AND = 4'd2,
    OPC_OR  = 4'd3,
    OPC_XOR = 4'd4,
    OPC_SLL = 4'd5,
    OPC_SRL = 4'd6,
    OPC_MUL = 4'd7,
    OPC_DIV = 4'd8,
    OPC_MOD = 4'd9
  } opcode_e;

  // Pipeline buffer layout, read field-by-field by the memory stage
  localparam int F_ADDR1_LSB  = 0;
  localparam int F_ADDR2_LSB  = 24;
  localparam int F_WDATA_LSB  = 48;
  localparam int F_RC_LSB     = 72;
  localparam int F_REGWRITE   = 76;
  localparam int F_MEMTOREG   = 77;
  localparam int F_MEMWRITE   = 78;
  localparam int F_OPCODE_LSB = 79;
  localparam int F_OPTYPE_LSB = 83;
  localparam int F_MODESEL    = 85;

  // True for ops that go through the iterative multiply/divide unit
  function automatic logic is_muldiv(input logic [1:0] op_type, input logic [3:0] op_code);
    return (op_type == OPT_ALU) &&
           ((op_code == OPC_MUL) || (op_code == OPC_DIV) || (op_code == OPC_MOD));
  endfunction

endpackage

// File: rtl/buffer.sv
// Purpose: generic enable-gated pipeline register of Buffer_size bits.
// Latency: 1 cycle when en=1.
// Backpressure: none; en=0 holds the current contents.
module buffer #(
  parameter int Buffer_size = 86
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [Buffer_size-1:0] i_d,
  output logic [Buffer_size-1:0] o_q
);

  logic [Buffer_size-1:0] r_q;

  // Capture the next stage word on every enabled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/iterative_muldiv.sv
// Purpose: 24-bit unsigned iterative multiply (low half) / divide / modulo, one bit per cycle.
// Latency: 1 latch cycle + MULDIV_CYCLES busy cycles, result valid in DONE.
// Backpressure: en=0 freezes state, counter and working registers.
module iterative_muldiv
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [4:0] CNT_LAST = 5'(MULDIV_CYCLES - 1);

  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  logic              r_is_mul;
  logic              r_want_quot;
  // acc: product accumulator (MUL) or partial remainder (DIV/MOD)
  // x:   multiplier shifting right (MUL) or dividend->quotient shifting left (DIV/MOD)
  // y:   multiplicand shifting left (MUL) or fixed divisor (DIV/MOD)
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;

  logic [DATA_W:0]   w_rem_sh;
  logic              w_ge;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_x_nxt;
  logic [DATA_W-1:0] w_y_nxt;

  // One shift-add or restoring-divide step; a zero divisor naturally yields
  // an all-ones quotient and the dividend as remainder
  always_comb begin
    w_rem_sh = {r_acc, r_x[DATA_W-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_y});
    if (r_is_mul) begin
      w_acc_nxt = r_acc + (r_x[0] ? r_y : '0);
      w_x_nxt   = r_x >> 1;
      w_y_nxt   = r_y << 1;
    end else begin
      w_acc_nxt = w_ge ? (w_rem_sh[DATA_W-1:0] - r_y) : w_rem_sh[DATA_W-1:0];
      w_x_nxt   = {r_x[DATA_W-2:0], w_ge};
      w_y_nxt   = r_y;
    end
  end

  // IDLE -> BUSY on start, MULDIV_CYCLES steps, then a single DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_mul    <= 1'b0;
      r_want_quot <= 1'b0;
      r_acc       <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_BUSY;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_is_mul    <= (op == OPC_MUL);
            r_want_quot <= (op == OPC_DIV);
            r_x         <= (op == OPC_MUL) ? b : a;
            r_y         <= (op == OPC_MUL) ? a : b;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = (r_state == S_BUSY);
  assign done   = (r_state == S_DONE);
  assign result = r_want_quot ? r_x : r_acc;

endmodule

// File: rtl/execute_stage.sv
// Purpose: execute stage - ALU, address generation, iterative mul/div, registered into the memory-stage buffer.
// Latency: 1 cycle for single-cycle ops; 26 edges for MUL/DIV/MOD.
// Backpressure: stall holds upstream during mul/div and loads bubbles; en=0 freezes everything.
module execute_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              modeSel,
  input  logic [1:0]        opType,
  input  logic [3:0]        opCode,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              regWrite,
  input  logic [3:0]        Rc,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic [DATA_W-1:0] storeData,
  output logic              stall,
  output logic [BUF_W-1:0]  bufferOut
);

  logic              w_start;
  logic              w_busy;
  logic              w_done;
  logic              w_stall;
  logic [DATA_W-1:0] w_md_result;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_result;
  logic [BUF_W-1:0]  w_buf_d;

  assign w_start = is_muldiv(opType, opCode);
  // Stall while busy, and combinationally as soon as a new mul/div is presented in IDLE
  assign w_stall = !rst && (w_busy || (!w_busy && !w_done && w_start));
  assign stall   = w_stall;

  iterative_muldiv u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (w_start),
    .op     (opCode),
    .a      (srcA),
    .b      (srcB),
    .busy   (w_busy),
    .done   (w_done),
    .result (w_md_result)
  );

  // Single-cycle ALU; mul/div codes take the iterative unit's result
  always_comb begin
    w_shamt = srcB[4:0];
    w_alu   = '0;
    case (opCode)
      OPC_ADD: w_alu = srcA + srcB;
      OPC_SUB: w_alu = srcA - srcB;
      OPC_AND: w_alu = srcA & srcB;
      OPC_OR:  w_alu = srcA | srcB;
      OPC_XOR: w_alu = srcA ^ srcB;
      OPC_SLL: w_alu = (w_shamt >= 5'd24) ? '0 : (srcA << w_shamt);
      OPC_SRL: w_alu = (w_shamt >= 5'd24) ? '0 : (srcA >> w_shamt);
      OPC_MUL, OPC_DIV, OPC_MOD: w_alu = w_md_result;
      default: w_alu = '0;
    endcase
  end

  // Result select by op class: ALU, memory address, or move
  always_comb begin
    w_result = srcB;
    case (opType)
      OPT_ALU: w_result = w_alu;
      OPT_MEM: w_result = srcA + srcB;
      default: w_result = srcB;
    endcase
  end

  // Pack the buffer word; a stall cycle inserts an all-zero bubble
  always_comb begin
    w_buf_d = '0;
    if (!w_stall) begin
      w_buf_d[F_MODESEL]              = modeSel;
      w_buf_d[F_OPTYPE_LSB +: 2]      = opType;
      w_buf_d[F_OPCODE_LSB +: 4]      = opCode;
      w_buf_d[F_MEMWRITE]             = memWrite;
      w_buf_d[F_MEMTOREG]             = memToReg;
      w_buf_d[F_REGWRITE]             = regWrite;
      w_buf_d[F_RC_LSB +: 4]          = Rc;
      w_buf_d[F_WDATA_LSB +: DATA_W]  = storeData;
      w_buf_d[F_ADDR2_LSB +: DATA_W]  = srcB;
      w_buf_d[F_ADDR1_LSB +: DATA_W]  = w_result;
    end
  end

  buffer #(
    .Buffer_size (BUF_W)
  ) u_buffer (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .i_d (w_buf_d),
    .o_q (bufferOut)
  );

endmodule

// File: tb/tb_execute_stage.sv
// Purpose: scoreboard bench for execute_stage - per-feature tasks, expected words queued at drive time.
// Latency: checks 1-cycle ALU ops and 26-edge mul/div ops, including en freeze and async reset.
// Backpressure: counts stall cycles and checks every stall edge loads a zero bubble.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        modeSel;
  logic [1:0]  opType;
  logic [3:0]  opCode;
  logic        memWrite;
  logic        memToReg;
  logic        regWrite;
  logic [3:0]  Rc;
  logic [23:0] srcA;
  logic [23:0] srcB;
  logic [23:0] storeData;
  logic        stall;
  logic [85:0] bufferOut;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [85:0] exp_q[$];

  execute_stage dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .modeSel   (modeSel),
    .opType    (opType),
    .opCode    (opCode),
    .memWrite  (memWrite),
    .memToReg  (memToReg),
    .regWrite  (regWrite),
    .Rc        (Rc),
    .srcA      (srcA),
    .srcB      (srcB),
    .storeData (storeData),
    .stall     (stall),
    .bufferOut (bufferOut)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference result straight from the operation definitions
  function automatic logic [23:0] model_res(input logic [1:0] t, input logic [3:0] c,
                                            input logic [23:0] a, input logic [23:0] b);
    if (t == 2'b01) return a + b;
    if (t[1]) return b;
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (b[4:0] >= 5'd24) ? 24'h0 : (a << b[4:0]);
      4'd6: return (b[4:0] >= 5'd24) ? 24'h0 : (a >> b[4:0]);
      4'd7: return a * b;
      4'd8: return (b == 24'h0) ? 24'hFFFFFF : (a / b);
      4'd9: return (b == 24'h0) ? a : (a % b);
      default: return 24'h0;
    endcase
  endfunction

  // Present one op at a falling edge and queue the buffer word it must produce
  task automatic drive_op(input logic [1:0] t, input logic [3:0] c, input logic [23:0] a,
                          input logic [23:0] b, input logic [23:0] sd, input logic [3:0] rc,
                          input logic mode, input logic mw, input logic m2r, input logic rw);
    @(negedge clk);
    opType = t; opCode = c; srcA = a; srcB = b; storeData = sd; Rc = rc;
    modeSel = mode; memWrite = mw; memToReg = m2r; regWrite = rw;
    exp_q.push_back({mode, t, c, mw, m2r, rw, rc, sd, b, model_res(t, c, a, b)});
  endtask

  // Clock until the op is accepted; report stall cycles, non-zero bubbles and the loaded word
  task automatic wait_result(input int en_off_at, output int stalls, output int bad_bubbles,
                             output logic [85:0] obs, output bit timeout);
    logic s;
    stalls = 0; bad_bubbles = 0; obs = 'x; timeout = 1'b1;
    for (int i = 0; i < 200; i++) begin
      en = (en_off_at >= 0 && i >= en_off_at && i < en_off_at + 5) ? 1'b0 : 1'b1;
      #1;
      s = stall;
      @(posedge clk);
      #1;
      if (s) begin
        stalls++;
        if (bufferOut !== 86'h0) bad_bubbles++;
      end else begin
        obs = bufferOut;
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; modeSel = 1'b1; opType = 2'b00; opCode = 4'd7;
    memWrite = 1'b1; memToReg = 1'b1; regWrite = 1'b1; Rc = 4'hF;
    srcA = 24'h5; srcB = 24'h3; storeData = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (bufferOut !== 86'h0) begin err_cnt++; $display("FAIL reset_buffer got=%h want=0", bufferOut); end
    vec_cnt++;
    if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got=%b want=0", stall); end
    @(negedge clk);
    opCode = 4'd0; modeSel = 1'b0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_release_stall got=%b want=0", stall); end
  endtask

  task automatic test_add();
    int st, bb; bit to; logic [85:0] obs, exp;
    drive_op(2'b00, 4'd0, 24'h000005, 24'h000003, 24'h0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result(-1, st, bb, obs, to);
    exp = exp_q.pop_front();
    vec_cnt++;
    if (to || obs !== exp) begin err_cnt++; $display("FAIL add_word got=%h want=%h", obs, exp); end
    vec_cnt++;
    if (obs[23:0] !== 24'h000008 || obs[75:72] !== 4'h2 || obs[76] !== 1'b1) begin
      err_cnt++; $display("FAIL add_fields got=%h want res=000008 rc=2 rw=1", obs);
    end
    vec_cnt++;
    if (st !== 0) begin err_cnt++; $display("FAIL add_stall got=%0d want=0", st); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  opc  [9] = '{4'd1, 4'd5, 4'd6, 4'd2, 4'd3, 4'd4, 4'd12, 4'd5, 4'd5};
    logic [23:0] a_v  [9] = '{24'h000000, 24'h000001, 24'h800000, 24'hF0F0F0, 24'hF0F0F0,
                              24'hFFFF00, 24'h123456, 24'h000001, 24'h000ABC};
    logic [23:0] b_v  [9] = '{24'h000001, 24'h000018, 24'h000004, 24'h3C3C3C, 24'h0F0F00,
                              24'h0F0F0F, 24'h654321, 24'h000017, 24'h000020};
    logic [23:0] r_v  [9] = '{24'hFFFFFF, 24'h000000, 24'h080000, 24'h303030, 24'hFFFFF0,
                              24'hF0F00F, 24'h000000, 24'h800000, 24'h000ABC};
    int st, bb; bit to; logic [85:0] obs, exp;
    for (int i = 0; i < 9; i++) begin
      drive_op(2'b00, opc[i], a_v[i], b_v[i], 24'h5A5A5A, 4'(i), i[0], 1'b0, i[1], 1'b1);
      wait_result(-1, st, bb, obs, to);
      exp = exp_q.pop_front();
      vec_cnt++;
      if (to || obs !== exp) begin err_cnt++; $display("FAIL alu%0d_word got=%h want=%h", i, obs, exp); end
      vec_cnt++;
      if (obs[23:0] !== r_v[i]) begin err_cnt++; $display("FAIL alu%0d_result got=%h want=%h", i, obs[23:0], r_v[i]); end
      vec_cnt++;
      if (st !== 0) begin err_cnt++; $display("FAIL alu%0d_stall got=%0d want=0", i, st); end
    end
  endtask

  task automatic test_mem_move();
    int st, bb; bit to; logic [85:0] obs, exp;
    drive_op(2'b01, 4'd0, 24'h000100, 24'h000020, 24'hABCDEF, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_result(-1, st, bb, obs, to);
    exp = exp_q.pop_front();
    vec_cnt++;
    if (to || obs !== exp) begin err_cnt++; $display("FAIL mem_word got=%h want=%h", obs, exp); end
    vec_cnt++;
    if (obs[23:0] !== 24'h000120 || obs[71:48] !== 24'hABCDEF || obs[47:24] !== 24'h000020 || obs[78] !== 1'b1) begin
      err_cnt++; $display("FAIL mem_fields got=%h want res=000120 wd=ABCDEF a2=000020 mw=1", obs);
    end
    // Move with a mul opcode must not enter the iterative unit
    drive_op(2'b10, 4'd7, 24'h111111, 24'h00BEEF, 24'h0, 4'h9, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_result(-1, st, bb, obs, to);
    exp = exp_q.pop_front();
    vec_cnt++;
    if (to || obs !== exp) begin err_cnt++; $display("FAIL move_word got=%h want=%h", obs, exp); end
    vec_cnt++;
    if (obs[23:0] !== 24'h00BEEF || st !== 0) begin
      err_cnt++; $display("FAIL move_result got=%h stalls=%0d want=00BEEF stalls=0", obs[23:0], st);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  opc [6] = '{4'd7, 4'd8, 4'd9, 4'd8, 4'd9, 4'd7};
    logic [23:0] a_v [6] = '{24'h000123, 24'd100, 24'd100, 24'd5, 24'd5, 24'hFFFFFF};
    logic [23:0] b_v [6] = '{24'h000010, 24'd7, 24'd7, 24'd0, 24'd0, 24'hFFFFFF};
    logic [23:0] r_v [6] = '{24'h001230, 24'h00000E, 24'h000002, 24'hFFFFFF, 24'h000005, 24'h000001};
    int st, bb; bit to; logic [85:0] obs, exp;
    for (int i = 0; i < 6; i++) begin
      drive_op(2'b00, opc[i], a_v[i], b_v[i], 24'h00C0DE, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_result(-1, st, bb, obs, to);
      exp = exp_q.pop_front();
      vec_cnt++;
      if (to || obs !== exp) begin err_cnt++; $display("FAIL md%0d_word got=%h want=%h", i, obs, exp); end
      vec_cnt++;
      if (obs[23:0] !== r_v[i]) begin err_cnt++; $display("FAIL md%0d_result got=%h want=%h", i, obs[23:0], r_v[i]); end
      vec_cnt++;
      if (st !== 25) begin err_cnt++; $display("FAIL md%0d_stall got=%0d want=25", i, st); end
      vec_cnt++;
      if (bb !== 0) begin err_cnt++; $display("FAIL md%0d_bubbles nonzero=%0d want=0", i, bb); end
    end
  endtask

  task automatic test_en_freeze();
    int st, bb; bit to; logic [85:0] obs, exp;
    drive_op(2'b00, 4'd7, 24'h000123, 24'h000010, 24'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_result(8, st, bb, obs, to);
    exp = exp_q.pop_front();
    vec_cnt++;
    if (to || obs !== exp) begin err_cnt++; $display("FAIL freeze_word got=%h want=%h", obs, exp); end
    vec_cnt++;
    if (obs[23:0] !== 24'h001230) begin err_cnt++; $display("FAIL freeze_result got=%h want=001230", obs[23:0]); end
    vec_cnt++;
    if (st !== 30 || bb !== 0) begin err_cnt++; $display("FAIL freeze_stall got=%0d bubbles=%0d want=30 bubbles=0", st, bb); end
  endtask

  task automatic test_reset_mid_busy();
    int st, bb; bit to; logic [85:0] obs, exp;
    @(negedge clk);
    en = 1'b1; opType = 2'b00; opCode = 4'd7; srcA = 24'h000123; srcB = 24'h000010;
    regWrite = 1'b1; Rc = 4'h4;
    repeat (11) @(posedge clk);
    #2;
    vec_cnt++;
    if (stall !== 1'b1) begin err_cnt++; $display("FAIL midbusy_stall got=%b want=1", stall); end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b0 || bufferOut !== 86'h0) begin
      err_cnt++; $display("FAIL midbusy_reset stall=%b buf=%h want stall=0 buf=0", stall, bufferOut);
    end
    drive_op(2'b00, 4'd0, 24'h000007, 24'h000008, 24'h0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    wait_result(-1, st, bb, obs, to);
    exp = exp_q.pop_front();
    vec_cnt++;
    if (to || obs !== exp || obs[23:0] !== 24'h00000F) begin
      err_cnt++; $display("FAIL after_reset_word got=%h want=%h", obs, exp);
    end
    vec_cnt++;
    if (st !== 0) begin err_cnt++; $display("FAIL after_reset_stall got=%0d want=0", st); end
  endtask

  task automatic test_random_muldiv();
    int st, bb; bit to; logic [85:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      drive_op(2'b00, 4'(7 + $urandom_range(0, 2)), 24'($urandom), 24'($urandom_range(0, 5000)),
               24'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1, 1'b1);
      wait_result(-1, st, bb, obs, to);
      exp = exp_q.pop_front();
      vec_cnt++;
      if (to || obs !== exp || st !== 25 || bb !== 0) begin
        err_cnt++; $display("FAIL rnd%0d got=%h stalls=%0d want=%h stalls=25", i, obs, st, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mem_move();
    test_back_to_back();
    test_en_freeze();
    test_reset_mid_busy();
    test_random_muldiv();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Pipeline execute stage sitting directly upstream of the memory stage. It computes ALU results and memory addresses from decoded operands and runs an iterative 24-bit multiply/divide unit. It stalls the front end while that unit is busy. Results and control are registered into an 86-bit pipeline buffer whose fields feed the memory stage's address1/address2/writeData/control inputs.

Parameters:
DATA_W, 24, operand/result width
MULDIV_CYCLES, 24, BUSY cycles per iterative op (equals DATA_W)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
en  input  1  global pipeline enable; 0 freezes FSM, counter and buffer
modeSel  input  1  pass-through control
opType  input  2  00 ALU, 01 memory, 10/11 move
opCode  input  4  ALU operation select
memWrite, memToReg, regWrite  input  1 each  pass-through control
Rc  input  4  destination register
srcA, srcB  input  24  operands
storeData  input  24  store data for memory ops
stall  output  1  high: upstream must hold inputs stable
bufferOut  output  86  |85 modeSel|84:83 opType|82:79 opCode|78 memWrite|77 memToReg|76 regWrite|75:72 Rc|71:48 writeData|47:24 address2|23:0 address1(result)|

Behaviour:
- Clock and reset: clk only; rst is asynchronous, active-high. Reset clears bufferOut to 0, FSM to IDLE and counter to 0, and forces stall=0 while rst is high.
- opType 00, single-cycle ops by opCode:
  - 0 ADD, 1 SUB: mod 2^24; 0-1 = FFFFFF.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: logical shift by srcB[4:0]; a shift amount of 24 or more gives 0.
  - 10-15 give result 0.
- opType 00, multi-cycle ops:
  - 7 MUL: low 24 bits of the unsigned product.
  - 8 DIV: unsigned quotient.
  - 9 MOD: unsigned remainder.
  - Divide by zero: quotient FFFFFF, remainder = srcA.
- opType 01: result = srcA+srcB (mod 2^24).
- opType 10/11: result = srcB.
- address2 = srcB and writeData = storeData for all ops.
- Single-cycle ops have 1-cycle latency: the buffer loads at the next clk edge when en=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with a multi-cycle op at the inputs: stall=1 combinationally, operands latched, counter=0, go to BUSY at the edge (when en=1).
  - BUSY: stall=1. One shift-add or restoring-divide step per en cycle. Counter increments; at counter=MULDIV_CYCLES-1, go to DONE.
  - DONE: stall=0, the result mux selects the iterative result, the buffer loads, next state IDLE.
  - Totals: stall high for 25 cycles; the result reaches bufferOut at the 26th edge after presentation.
- While stall=1 and en=1, the buffer loads a bubble: all 14 control bits 0, data fields 0. The memory stage therefore never sees a duplicate op.
- en=0: nothing changes. stall keeps its current value.
- Back-to-back multi-cycle ops: after DONE the FSM is in IDLE, so the next op immediately re-stalls. There are no idle gaps beyond this.
- Reset mid-BUSY: the operation is abandoned, with no partial result in the buffer.

Decomposition:
- Package exec_pkg:
  - opType/opCode enums.
  - DATA_W.
  - Buffer field bit positions (shared with the memory stage).
  - Helper function is_muldiv(opType, opCode).
- Sub-module iterative_muldiv:
  - Ports: start, op, a, b in; busy, done, result out.
  - Contains the FSM and counter.
- Output register: instantiate the existing parameterised buffer with Buffer_size=86.

Test Plan:
- ADD srcA=000005, srcB=000003, Rc=4'h2, regWrite=1, en=1 -> next edge bufferOut[23:0]=000008, [75:72]=2, [76]=1, stall never high.
- SUB srcA=000000, srcB=000001; then SLL srcA=000001, srcB=000018 -> results FFFFFF, then 000000.
- MUL srcA=000123, srcB=000010 -> stall high exactly 25 cycles, bubbles (bufferOut=0) during the stall, then [23:0]=001230.
- DIV 100/7 then MOD 100/7 back-to-back -> results 00000E then 000002, each preceded by a 25-cycle stall. DIV 5/0 -> FFFFFF; MOD 5/0 -> 000005.
- Memory op opType=01, srcA=000100, srcB=000020, storeData=ABCDEF, memWrite=1 -> [23:0]=000120, [71:48]=ABCDEF, [47:24]=000020, [78]=1.
- rst pulse at BUSY cycle 10 -> bufferOut=0 and stall=0 immediately (asynchronously). en=0 held for 5 cycles mid-MUL -> the stall window extends by 5 and the result is still 001230.
